// File: rtl/bus_tx_ctrl.sv
// Buffered transmit controller feeding the tristate bus driver.
// Words are queued in a small FIFO and driven onto the bus one per cycle
// while the bus is granted. After each release the bus is left idle for a
// turnaround gap so that two owners never overlap.
module bus_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TURN  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     bus_grant,
  output logic                     data_en,
  output logic [WIDTH-1:0]         data_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  // The turnaround counter holds TURN-1 at most; keep it at least 1 bit wide.
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  state_t           state, state_nx;
  logic [TW-1:0]    turn_cnt, turn_cnt_nx;
  logic             push, pop, en_nx;

  // Ready depends on occupancy only, so a full FIFO never accepts a word
  // even on a cycle that pops.
  assign in_ready = (count < (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  // FIFO storage; contents need no reset since pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state, turnaround counter and the registered driver inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      turn_cnt <= '0;
      data_en  <= 1'b0;
      data_in  <= '0;
    end else begin
      state    <= state_nx;
      turn_cnt <= turn_cnt_nx;
      data_en  <= en_nx;
      if (pop) data_in <= mem[rd_ptr];
    end
  end

  // Next-state, pop and next data_en. The FIFO is judged by the registered
  // count, so a word pushed this cycle is not seen until the next one.
  always_comb begin
    state_nx    = state;
    turn_cnt_nx = turn_cnt;
    pop         = 1'b0;
    en_nx       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0 && bus_grant) begin
          pop      = 1'b1;
          en_nx    = 1'b1;
          state_nx = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (bus_grant && count != '0) begin
          pop   = 1'b1;
          en_nx = 1'b1;
        end else if (TURN > 0) begin
          state_nx    = ST_TURN;
          turn_cnt_nx = TW'(TURN - 1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_TURN: begin
        // Grant and FIFO contents are ignored until the gap has elapsed.
        if (turn_cnt == '0) state_nx = ST_IDLE;
        else                turn_cnt_nx = turn_cnt - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_tx_ctrl.sv
// Bench for bus_tx_ctrl: directed stimulus pushes expected bus words into a
// scoreboard queue; an independent monitor pops and compares each driven word,
// and also checks the turnaround gap and that data_in holds while idle.
module tb_bus_tx_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TURN  = 2;

  logic                   clk, reset_n, in_valid, bus_grant;
  logic                   in_ready, data_en, busy;
  logic [WIDTH-1:0]       in_data, data_in;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  bus_tx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TURN(TURN)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bus_grant(bus_grant), .data_en(data_en),
    .data_in(data_in), .busy(busy), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present one word for one cycle; the bench states whether it must be taken.
  task automatic offer(input logic [WIDTH-1:0] w, input logic accept);
    in_valid = 1'b1;
    in_data  = w;
    chk("in_ready", in_ready, accept);
    if (accept) exp_q.push_back(w);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: compares driven words with the scoreboard, enforces the idle gap
  // after a release and checks that data_in holds while not driving.
  logic             prev_en   = 1'b0;
  logic             released  = 1'b0;
  int               idle_run  = 0;
  logic [WIDTH-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_en   = 1'b0;
      released  = 1'b0;
      idle_run  = 0;
      prev_data = '0;
    end else begin
      if (data_en) begin
        if (!prev_en && released)
          chk("turn_gap", (idle_run >= TURN + 1), 1'b1);
        if (exp_q.size() == 0) begin
          chk("unexpected_drive", data_in, 32'hDEAD);
        end else begin
          chk("bus_word", data_in, exp_q.pop_front());
        end
      end else begin
        chk("data_in_hold", data_in, prev_data);
        if (prev_en) begin
          released = 1'b1;
          idle_run = 1;
        end else begin
          idle_run++;
        end
      end
      prev_en   = data_en;
      prev_data = data_in;
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bus_grant = 1'b0;

    // 1. Reset and idle
    step(3);
    reset_n = 1'b1;
    step();
    chk("rst_data_en", data_en, 1'b0);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // 2. Single word with grant held: two-cycle latency, one-cycle drive, gap
    bus_grant = 1'b1;
    offer(8'h55, 1'b1);
    chk("s2_lat1_en", data_en, 1'b0);
    chk("s2_count1", count, 1);
    step();
    chk("s2_lat2_en", data_en, 1'b1);
    step();
    chk("s2_release_en", data_en, 1'b0);
    chk("s2_busy_turn", busy, 1'b1);
    step();
    chk("s2_busy_turn2", busy, 1'b1);
    step();
    chk("s2_busy_idle", busy, 1'b0);
    chk("s2_drained", exp_q.size(), 0);

    // 3. Fill with grant low, reject 5th word, then burst
    bus_grant = 1'b0;
    offer(8'h11, 1'b1);
    offer(8'h22, 1'b1);
    offer(8'h33, 1'b1);
    offer(8'h44, 1'b1);
    chk("s3_count_full", count, 4);
    offer(8'h55, 1'b0);
    chk("s3_count_still", count, 4);
    bus_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s3_burst_en", data_en, 1'b1);
    end
    step();
    chk("s3_release_en", data_en, 1'b0);
    chk("s3_drained", exp_q.size(), 0);
    step(3);

    // 4. Grant drop after 8'h22, resume with 8'h33/8'h44
    bus_grant = 1'b0;
    offer(8'h11, 1'b1);
    offer(8'h22, 1'b1);
    offer(8'h33, 1'b1);
    offer(8'h44, 1'b1);
    bus_grant = 1'b1;
    step(2);
    chk("s4_word22", data_in, 8'h22);
    bus_grant = 1'b0;
    step();
    chk("s4_drop_en", data_en, 1'b0);
    chk("s4_drop_count", count, 2);
    step(3);
    bus_grant = 1'b1;
    step(4);
    chk("s4_drained", exp_q.size(), 0);
    step(3);

    // 5. Word pushed as the FIFO empties in DRIVE waits out the turnaround
    chk("s5_idle", busy, 1'b0);
    offer(8'h5A, 1'b1);
    step();
    chk("s5_drive_en", data_en, 1'b1);
    offer(8'hAA, 1'b1);
    chk("s5_turn_en0", data_en, 1'b0);
    step();
    chk("s5_turn_en1", data_en, 1'b0);
    step();
    chk("s5_turn_en2", data_en, 1'b0);
    step();
    chk("s5_aa_en", data_en, 1'b1);
    chk("s5_aa_data", data_in, 8'hAA);
    step(4);
    chk("s5_drained", exp_q.size(), 0);

    // 6. Asynchronous reset mid-burst discards the queued words
    bus_grant = 1'b0;
    offer(8'h01, 1'b1);
    offer(8'h02, 1'b1);
    offer(8'h03, 1'b1);
    bus_grant = 1'b1;
    step();
    chk("s6_driving", data_en, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk("s6_async_en", data_en, 1'b0);
    chk("s6_async_count", count, 0);
    chk("s6_async_data", data_in, 8'h00);
    chk("s6_async_busy", busy, 1'b0);
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step();
    chk("s6_count", count, 0);
    chk("s6_in_ready", in_ready, 1'b1);
    step(6);
    chk("s6_no_stale_en", data_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_tx_ctrl.md
Name: bus_tx_ctrl

Overview:
Buffered transmit controller that sits directly upstream of the tristate `driver` block and generates its `data_en`/`data_in` inputs. Words arrive over a valid/ready interface and are queued in an internal FIFO. Queued words are driven onto the shared bus one per cycle while the arbiter grants the bus. After every release the controller enforces a turnaround gap so that two bus owners never overlap.

Parameters:
WIDTH, 8, data word width; must match the `driver` WIDTH.
DEPTH, 4, FIFO depth in words; a power of 2, at least 2.
TURN, 2, idle cycles with `data_en`=0 enforced after each release; 0 is legal.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  FIFO can accept a word.
in_data  input  WIDTH  upstream word.
bus_grant  input  1  arbiter grant; the controller may drive only while this is high.
data_en  output  1  to `driver` `data_en`; registered.
data_in  output  WIDTH  to `driver` `data_in`; registered.
busy  output  1  high when the FSM is in DRIVE or TURN.
count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
Reset
- reset_n low asynchronously clears: FIFO pointers, count=0, data_en=0, data_in=0, state=IDLE, turnaround counter=0.
- In particular, data_en falls immediately, even mid-DRIVE.
- in_ready=1 once reset is released.

FIFO
- in_ready = (count < DEPTH), combinational from count only.
- Push occurs when in_valid && in_ready.
- When full, in_ready stays 0 even on a cycle that pops; there is no push-through.
- A pushed word becomes visible to the FSM one cycle later.
- Pointers wrap modulo DEPTH.
- count updates each cycle as +1 on push, -1 on pop, unchanged on simultaneous push and pop.

FSM states: IDLE, DRIVE, TURN.
- IDLE
  - data_en=0.
  - If count>0 && bus_grant: at the next edge data_en<=1, data_in<=head word, pop, go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE
  - On each cycle, if bus_grant && count>0: at the next edge data_in<=head word, pop, stay in DRIVE (data_en stays 1).
  - Otherwise: at the next edge data_en<=0, data_in holds its last value. Go to TURN with the counter loaded to TURN-1 if TURN>0; go to IDLE if TURN==0.
- TURN
  - data_en=0.
  - Counter decrements each cycle; at 0, go to IDLE.
  - bus_grant and FIFO contents are ignored while in TURN.

Timing and latency
- Latency from the first push into an empty FIFO with grant held high to data_en=1 is 2 cycles.
- Back-to-back words are driven on consecutive cycles with no bubbles while grant stays high and the FIFO is non-empty.
- Words are driven in FIFO order; none are lost or duplicated.

Boundary conditions
- bus_grant dropping mid-burst: the word currently on the bus completes its cycle. No further pop occurs, and unsent words remain queued.
- FIFO empties in DRIVE while a push arrives the same cycle: the FIFO is seen as empty, so the controller releases and turns around before driving that word.
- data_in changes only on a pop edge or on reset.
- busy = (state != IDLE).

Test Plan:
1. Reset and idle: hold reset_n=0, then release with bus_grant=0. Required: data_en=0, data_in=8'h00, count=0, in_ready=1, busy=0.
2. Single word: push 8'h55 with bus_grant=1. Required: 2 cycles later data_en=1, data_in=8'h55 for exactly 1 cycle, then data_en=0 for 2 cycles (TURN), then IDLE; downstream driver output shows 8'h55 then Z.
3. Burst and full:
   - With bus_grant=0, push 8'h11, 8'h22, 8'h33, 8'h44. Required: count=4, in_ready=0; a 5th push of 8'h55 is not accepted.
   - Then raise bus_grant. Required: data_in shows 11, 22, 33, 44 on 4 consecutive cycles with data_en=1, then release.
4. Grant drop: during the burst of scenario 3, drop bus_grant after 8'h22 is driven. Required: data_en=0 on the next cycle, count=2. On re-grant after TURN, the sequence resumes with 8'h33, 8'h44.
5. Turnaround enforcement: keep bus_grant=1 and push a new word 8'hAA during TURN. Required: data_en stays 0 until TURN expires, and 8'hAA is driven only after that.
6. Async reset mid-burst: assert reset_n=0 between clock edges while data_en=1. Required: data_en=0 immediately, with no clock edge needed; count=0 and in_ready=1 after release; the stale words are never driven.
